tdc_chnl_buffer: RTL and testbench
==================================

TDC_CHNL_BUFFER -- requirements
Module: tdc_chnl_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 16, FIFO entries (power of 2, 4..256).
REQ-002 SHALL have parameter TDC_ID, default 8'h00, channel tag inserted in overflow markers.
REQ-003 SHALL have port clk  in  1  clock; reset rst, synchronous, active-high; clock clk.
REQ-004 SHALL have port rst  in  1  synchronous active-high reset.
REQ-005 SHALL have port in_valid  in  1  decoded TDC word strobe (chnl_data_valid of the phase-select stage).
REQ-006 SHALL have port in_data  in  32  decoded TDC word (chnl_data_32b).
REQ-007 SHALL have port clr_stats  in  1  synchronous clear of statistics outputs.
REQ-008 SHALL have port o_valid  out  1  head word available.
REQ-009 SHALL have port o_ready  in  1  downstream accepts head word.
REQ-010 SHALL have port o_data  out  32  head word.
REQ-011 SHALL have port fifo_count  out  log2(DEPTH)+1  current occupancy.
REQ-012 SHALL have port high_water  out  log2(DEPTH)+1  maximum occupancy since reset/clear.
REQ-013 SHALL have port overflow_total  out  32  saturating count of dropped words.
REQ-014 SHALL have port dropping  out  1  high while state is DROP.

Function
REQ-015 SHALL be a first-word-fall-through FIFO: o_valid = (fifo_count != 0); o_data = head entry, combinationally from storage.
REQ-016 SHALL pop the head when o_valid && o_ready; o_data SHALL hold stable while o_valid && !o_ready.
REQ-017 SHALL evaluate full on pre-pop occupancy: a write in a cycle with fifo_count==DEPTH SHALL be dropped even if a pop occurs in the same cycle.
REQ-018 SHALL implement a state machine with states NORMAL and DROP.
REQ-019 SHALL, in NORMAL, write in_data unchanged when in_valid && !full; write-to-o_valid latency is 1 cycle.
REQ-020 SHALL, in NORMAL, on in_valid && full: drop the word, set drop_cnt=1, and enter DROP.
REQ-021 SHALL, in DROP, drop every in_valid word and increment the 16-bit drop_cnt, saturating at 16'hFFFF.
REQ-022 SHALL, in DROP, on a cycle with in_valid=0 and pre-pop occupancy < DEPTH: write the marker {8'hEE, TDC_ID[7:0], drop_cnt[15:0]}, clear drop_cnt, and return to NORMAL.
REQ-023 SHALL increment overflow_total by 1 per dropped word, saturating at 32'hFFFF_FFFF.
REQ-024 SHALL update high_water to max(high_water, post-update fifo_count) every cycle.
REQ-025 SHALL, on clr_stats, zero overflow_total and load high_water with the current fifo_count; a same-cycle drop SHALL NOT be counted. FIFO contents, state and drop_cnt SHALL be unaffected.
REQ-026 SHALL wrap read/write pointers modulo DEPTH and keep fifo_count exact under simultaneous read and write (count unchanged).

Reset
REQ-027 SHALL, on rst, clear pointers, fifo_count, high_water, overflow_total and drop_cnt, and set state NORMAL; o_valid=0 and dropping=0 from the next cycle.
REQ-028 SHALL give rst priority over clr_stats, in_valid and o_ready; a reset mid-DROP SHALL discard pending drop_cnt without writing a marker.
REQ-029 SHALL NOT reset storage RAM contents.

Structure
REQ-030 SHALL place the marker byte constant 8'hEE and the NORMAL/DROP state type in the shared TDC readout package.
REQ-031 SHALL instantiate one sub-module, sync_fifo_fwft (storage, pointers, count); the drop/marker FSM and statistics live in tdc_chnl_buffer.

Verification
REQ-032 SHALL cover basic flow: o_ready=1, three words 0x11111111, 0x22222222, 0x33333333 -> emitted in order one cycle after each write; high_water=1.
REQ-033 SHALL cover overflow: DEPTH=16, o_ready=0, 20 writes -> fifo_count=16, overflow_total=4, dropping=1; one idle cycle after o_ready=1 -> marker 0xEE00_0004 follows the 16 data words.
REQ-034 SHALL cover the full-with-pop corner: full FIFO, in_valid and pop in the same cycle -> word dropped, fifo_count=15, state DROP.
REQ-035 SHALL cover the continuous-drop window: in DROP, in_valid held high 5 cycles while draining -> no marker until the first in_valid=0 cycle; marker count = total drops.
REQ-036 SHALL cover reset mid-DROP: rst asserted in DROP -> no marker, fifo_count=0, overflow_total=0 next cycle.
REQ-037 SHALL cover clr_stats: clr_stats with overflow_total=7 and fifo_count=3 -> overflow_total=0, high_water=3 next cycle.

Source files
------------

// File: rtl/tdc_chnl_buffer_pkg.sv
// Shared TDC readout definitions: overflow-marker format and drop-FSM state type.
package tdc_chnl_buffer_pkg;

  localparam logic [7:0]  MARKER_BYTE  = 8'hEE;
  localparam logic [15:0] DROP_CNT_MAX = 16'hFFFF;

  typedef enum logic {
    NORMAL = 1'b0,
    DROP   = 1'b1
  } drop_state_t;

  // Overflow marker: {EE, channel tag, number of words lost}
  function automatic logic [31:0] make_marker(input logic [7:0] id, input logic [15:0] cnt);
    return {MARKER_BYTE, id, cnt};
  endfunction

endpackage

// File: rtl/tdc_chnl_buffer_fifo.sv
// First-word-fall-through synchronous FIFO: storage, wrapping pointers and exact occupancy.
module sync_fifo_fwft #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr_en,
  input  logic [WIDTH-1:0]       wr_data,
  input  logic                   rd_en,
  output logic [WIDTH-1:0]       rd_data,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             wr_ok;
  logic             rd_ok;

  assign wr_ok   = wr_en && (count != FULL_CNT);
  assign rd_ok   = rd_en && (count != '0);
  assign rd_data = mem[rd_ptr];

  // Storage is deliberately left out of reset so it can map onto RAM.
  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
      if (rd_ok) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_ok, rd_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/tdc_chnl_buffer.sv
// Per-channel TDC word buffer: FWFT FIFO with overflow drop/marker FSM and occupancy statistics.
module tdc_chnl_buffer
  import tdc_chnl_buffer_pkg::*;
#(
  parameter int          DEPTH  = 16,
  parameter logic [7:0]  TDC_ID = 8'h00
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  input  logic [31:0]            in_data,
  input  logic                   clr_stats,
  output logic                   o_valid,
  input  logic                   o_ready,
  output logic [31:0]            o_data,
  output logic [$clog2(DEPTH):0] fifo_count,
  output logic [$clog2(DEPTH):0] high_water,
  output logic [31:0]            overflow_total,
  output logic                   dropping
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  drop_state_t   state, state_next;
  logic [15:0]   drop_cnt, drop_cnt_next;
  logic          wr_en;
  logic [31:0]   wr_data;
  logic          drop_word;
  logic          full;
  logic          pop;
  logic [CW-1:0] count_next;

  sync_fifo_fwft #(
    .DEPTH (DEPTH),
    .WIDTH (32)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_en),
    .wr_data (wr_data),
    .rd_en   (o_ready),
    .rd_data (o_data),
    .count   (fifo_count)
  );

  // Full is judged before any same-cycle pop, so a full FIFO never accepts a word.
  assign full       = (fifo_count == FULL_CNT);
  assign o_valid    = (fifo_count != '0);
  assign pop        = o_valid && o_ready;
  assign dropping   = (state == DROP);
  assign count_next = fifo_count + CW'(wr_en) - CW'(pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= NORMAL;
      drop_cnt <= '0;
    end else begin
      state    <= state_next;
      drop_cnt <= drop_cnt_next;
    end
  end

  // The marker waits for an in_valid gap so it never steals a slot from live data.
  always_comb begin
    state_next    = state;
    drop_cnt_next = drop_cnt;
    wr_en         = 1'b0;
    wr_data       = in_data;
    drop_word     = 1'b0;
    case (state)
      NORMAL: begin
        if (in_valid) begin
          if (full) begin
            drop_word     = 1'b1;
            drop_cnt_next = 16'd1;
            state_next    = DROP;
          end else begin
            wr_en = 1'b1;
          end
        end
      end
      DROP: begin
        if (in_valid) begin
          drop_word = 1'b1;
          if (drop_cnt != DROP_CNT_MAX) drop_cnt_next = drop_cnt + 16'd1;
        end else if (!full) begin
          wr_en         = 1'b1;
          wr_data       = make_marker(TDC_ID, drop_cnt);
          drop_cnt_next = '0;
          state_next    = NORMAL;
        end
      end
      default: state_next = NORMAL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      overflow_total <= '0;
      high_water     <= '0;
    end else if (clr_stats) begin
      overflow_total <= '0;
      high_water     <= fifo_count;
    end else begin
      if (drop_word && (overflow_total != 32'hFFFF_FFFF)) overflow_total <= overflow_total + 32'd1;
      if (count_next > high_water) high_water <= count_next;
    end
  end

endmodule

// File: tb/tb_tdc_chnl_buffer.sv
// Self-checking bench for tdc_chnl_buffer: queue-based reference model plus directed corner cases.
module tb_tdc_chnl_buffer;

  localparam int DEPTH = 16;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic [31:0] in_data;
  logic        clr_stats;
  logic        o_valid;
  logic        o_ready;
  logic [31:0] o_data;
  logic [4:0]  fifo_count;
  logic [4:0]  high_water;
  logic [31:0] overflow_total;
  logic        dropping;

  tdc_chnl_buffer #(
    .DEPTH  (DEPTH),
    .TDC_ID (8'h00)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .in_valid       (in_valid),
    .in_data        (in_data),
    .clr_stats      (clr_stats),
    .o_valid        (o_valid),
    .o_ready        (o_ready),
    .o_data         (o_data),
    .fifo_count     (fifo_count),
    .high_water     (high_water),
    .overflow_total (overflow_total),
    .dropping       (dropping)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;
  bit modelActive = 1'b0;

  // Reference model: a plain queue of words plus the drop bookkeeping.
  logic [31:0] mq[$];
  bit          mDrop = 1'b0;
  int          mDropCnt = 0;
  longint      mOverflow = 0;
  int          mHigh = 0;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual === expected) passes++;
    else $display("[TB] FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
  endtask

  // One clock cycle with the given inputs held; returns just after the edge.
  task automatic applyStimulus(input bit iv, input logic [31:0] d, input bit rdy, input bit clr, input bit r);
    in_valid  = iv;
    in_data   = d;
    o_ready   = rdy;
    clr_stats = clr;
    rst       = r;
    @(posedge clk);
    #1;
  endtask

  // Model update: applies the cycle's inputs exactly as the behavioural rules describe.
  always @(posedge clk) begin
    int  preCount;
    bit  isFull;
    bit  dropped;
    if (rst) begin
      mq.delete();
      mDrop     = 1'b0;
      mDropCnt  = 0;
      mOverflow = 0;
      mHigh     = 0;
    end else begin
      preCount = mq.size();
      isFull   = (preCount == DEPTH);
      dropped  = 1'b0;
      if (preCount != 0 && o_ready) void'(mq.pop_front());
      if (!mDrop) begin
        if (in_valid) begin
          if (isFull) begin
            dropped  = 1'b1;
            mDrop    = 1'b1;
            mDropCnt = 1;
          end else mq.push_back(in_data);
        end
      end else begin
        if (in_valid) begin
          dropped = 1'b1;
          if (mDropCnt < 65535) mDropCnt++;
        end else if (!isFull) begin
          mq.push_back({8'hEE, 8'h00, 16'(mDropCnt)});
          mDropCnt = 0;
          mDrop    = 1'b0;
        end
      end
      if (clr_stats) begin
        mOverflow = 0;
        mHigh     = preCount;
      end else begin
        if (dropped && mOverflow < 64'hFFFF_FFFF) mOverflow++;
        if (mq.size() > mHigh) mHigh = mq.size();
      end
    end
  end

  // Compare process: every cycle, away from the active edge.
  always @(negedge clk) begin
    if (modelActive) begin
      checkOutput("m_o_valid", 32'(o_valid), 32'(mq.size() != 0));
      if (mq.size() != 0) checkOutput("m_o_data", o_data, mq[0]);
      checkOutput("m_fifo_count", 32'(fifo_count), 32'(mq.size()));
      checkOutput("m_high_water", 32'(high_water), 32'(mHigh));
      checkOutput("m_overflow_total", overflow_total, mOverflow[31:0]);
      checkOutput("m_dropping", 32'(dropping), 32'(mDrop));
    end
  end

  logic [31:0] expWords[$];
  logic [31:0] lastWord;
  int          guard;

  initial begin
    in_valid = 0; in_data = 0; o_ready = 0; clr_stats = 0; rst = 1;
    applyStimulus(0, 0, 0, 0, 1);
    modelActive = 1'b1;
    $display("[TB] reset state");
    checkOutput("rst_o_valid", 32'(o_valid), 0);
    checkOutput("rst_fifo_count", 32'(fifo_count), 0);
    checkOutput("rst_dropping", 32'(dropping), 0);
    checkOutput("rst_overflow", overflow_total, 0);

    // Basic flow: each word visible one cycle after its write.
    $display("[TB] basic flow");
    applyStimulus(1, 32'h1111_1111, 1, 0, 0);
    checkOutput("basic_w1", o_data, 32'h1111_1111);
    applyStimulus(1, 32'h2222_2222, 1, 0, 0);
    checkOutput("basic_w2", o_data, 32'h2222_2222);
    applyStimulus(1, 32'h3333_3333, 1, 0, 0);
    checkOutput("basic_w3", o_data, 32'h3333_3333);
    checkOutput("basic_valid", 32'(o_valid), 1);
    applyStimulus(0, 0, 1, 0, 0);
    checkOutput("basic_empty", 32'(o_valid), 0);
    checkOutput("basic_high_water", 32'(high_water), 1);

    // Overflow: 20 writes into a stalled FIFO, then drain with the marker last.
    $display("[TB] overflow and marker");
    applyStimulus(0, 0, 0, 0, 1);
    expWords.delete();
    for (int i = 0; i < 20; i++) begin
      applyStimulus(1, 32'hA000_0000 + 32'(i), 0, 0, 0);
      if (i < 16) expWords.push_back(32'hA000_0000 + 32'(i));
    end
    expWords.push_back(32'hEE00_0004);
    checkOutput("ovf_count", 32'(fifo_count), 16);
    checkOutput("ovf_total", overflow_total, 4);
    checkOutput("ovf_dropping", 32'(dropping), 1);
    foreach (expWords[k]) begin
      checkOutput("ovf_drain_word", o_data, expWords[k]);
      applyStimulus(0, 0, 1, 0, 0);
    end
    checkOutput("ovf_drained", 32'(o_valid), 0);

    // Full FIFO with a same-cycle pop still drops the incoming word.
    $display("[TB] full with pop");
    applyStimulus(0, 0, 0, 0, 1);
    for (int i = 0; i < 16; i++) applyStimulus(1, 32'hB000_0000 + 32'(i), 0, 0, 0);
    applyStimulus(1, 32'hDEAD_BEEF, 1, 0, 0);
    checkOutput("fwp_count", 32'(fifo_count), 15);
    checkOutput("fwp_dropping", 32'(dropping), 1);
    checkOutput("fwp_total", overflow_total, 1);

    // Continuous drop window: no marker while in_valid stays high.
    $display("[TB] continuous drop window");
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1, 32'hC000_0000 + 32'(i), 1, 0, 0);
      checkOutput("cdw_still_dropping", 32'(dropping), 1);
    end
    checkOutput("cdw_count", 32'(fifo_count), 10);
    applyStimulus(0, 0, 1, 0, 0);
    checkOutput("cdw_back_normal", 32'(dropping), 0);
    checkOutput("cdw_total", overflow_total, 6);
    guard = 0;
    lastWord = '0;
    while (o_valid && guard < 40) begin
      lastWord = o_data;
      applyStimulus(0, 0, 1, 0, 0);
      guard++;
    end
    checkOutput("cdw_drain_bound", 32'(o_valid), 0);
    checkOutput("cdw_marker", lastWord, 32'hEE00_0006);

    // Reset in DROP discards the pending count; no marker appears afterwards.
    $display("[TB] reset mid-drop");
    applyStimulus(0, 0, 0, 0, 1);
    for (int i = 0; i < 19; i++) applyStimulus(1, 32'hD000_0000 + 32'(i), 0, 0, 0);
    checkOutput("rmd_dropping", 32'(dropping), 1);
    applyStimulus(0, 0, 1, 1, 1);
    checkOutput("rmd_count", 32'(fifo_count), 0);
    checkOutput("rmd_total", overflow_total, 0);
    checkOutput("rmd_dropping_cleared", 32'(dropping), 0);
    for (int i = 0; i < 3; i++) applyStimulus(0, 0, 1, 0, 0);
    checkOutput("rmd_no_marker", 32'(o_valid), 0);

    // clr_stats with overflow_total=7 and fifo_count=3.
    $display("[TB] clear statistics");
    applyStimulus(0, 0, 0, 0, 1);
    for (int i = 0; i < 23; i++) applyStimulus(1, 32'hE000_0000 + 32'(i), 0, 0, 0);
    for (int i = 0; i < 14; i++) applyStimulus(0, 0, 1, 0, 0);
    checkOutput("clr_pre_total", overflow_total, 7);
    checkOutput("clr_pre_count", 32'(fifo_count), 3);
    applyStimulus(0, 0, 0, 1, 0);
    checkOutput("clr_total", overflow_total, 0);
    checkOutput("clr_high_water", 32'(high_water), 3);
    checkOutput("clr_count_kept", 32'(fifo_count), 3);

    // Randomized traffic with alternating fast/slow drain phases.
    $display("[TB] random traffic");
    applyStimulus(0, 0, 0, 0, 1);
    for (int i = 0; i < 4000; i++) begin
      bit iv, rdy, clr, r;
      iv  = ($urandom_range(0, 9) < 6);
      rdy = ((i / 400) % 2 == 1) ? ($urandom_range(0, 9) < 2) : ($urandom_range(0, 9) < 7);
      clr = ($urandom_range(0, 63) == 0);
      r   = ($urandom_range(0, 499) == 0);
      applyStimulus(iv, $urandom, rdy, clr, r);
    end
    applyStimulus(0, 0, 1, 0, 0);
    @(negedge clk);
    modelActive = 1'b0;

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
